// File: rtl/gtxe2_rx_pkg.sv
// rtl/gtxe2_rx_pkg.sv - shared lane ordering, width helpers and defaults for the RX gearbox
package gtxe2_rx_pkg;

  // Lane 0 carries the first-received inner word and sits in the LSBs.
  localparam bit LANE0_IN_LSB = 1'b1;
  localparam int DEFAULT_LOG_DEPTH = 3;

  function automatic int iface_width(input int div, input int w);
    return div * w;
  endfunction

  function automatic int total_width(input int data_w, input int isk_w);
    return data_w + isk_w;
  endfunction

  function automatic int lane_lsb(input int lane, input int div, input int w);
    return LANE0_IN_LSB ? lane * w : (div - 1 - lane) * w;
  endfunction

endpackage

// File: rtl/gtxe2_chnl_rx_gearbox_if.sv
// rtl/gtxe2_chnl_rx_gearbox_if.sv - inner-word input and packed-word output handshake bundle
interface gtxe2_chnl_rx_gearbox_if
  import gtxe2_rx_pkg::*;
#(
  parameter int internal_data_width = 16,
  parameter int internal_isk_width  = 2,
  parameter int div                 = 2
);

  localparam int OW  = iface_width(div, internal_data_width);
  localparam int OKW = iface_width(div, internal_isk_width);

  logic [internal_data_width-1:0] indata;
  logic [internal_isk_width-1:0]  inisk;
  logic                           in_val;
  logic                           realign;
  logic [OW-1:0]                  outdata;
  logic [OKW-1:0]                 outisk;
  logic                           out_val;
  logic                           out_ready;

  modport master (
    output indata, inisk, in_val, realign, out_ready,
    input  outdata, outisk, out_val
  );

  modport slave (
    input  indata, inisk, in_val, realign, out_ready,
    output outdata, outisk, out_val
  );

endinterface

// File: rtl/gtxe2_chnl_rx_gearbox_fifo.sv
// rtl/gtxe2_chnl_rx_gearbox_fifo.sv - single-clock show-ahead FIFO with occupancy output
module gtxe2_chnl_rx_gearbox_fifo #(
  parameter int width     = 8,
  parameter int log_depth = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [width-1:0]   push_data,
  input  logic               pop,
  output logic [width-1:0]   pop_data,
  output logic               full,
  output logic               empty,
  output logic [log_depth:0] level
);

  localparam int DEPTH = 2 ** log_depth;
  localparam logic [log_depth:0] FULL_LEVEL = DEPTH[log_depth:0];

  logic [width-1:0]   mem_q [DEPTH];
  logic [log_depth:0] wr_ptr_q, wr_ptr_d;
  logic [log_depth:0] rd_ptr_q, rd_ptr_d;
  logic               do_push;
  logic               do_pop;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == FULL_LEVEL);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot in the same edge, so a full FIFO still accepts a push alongside it.
  assign do_push = push & (~full | pop);

  // Gating keeps the head at zero while empty, which also covers the post-reset value.
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q[log_depth-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (log_depth+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (log_depth+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[log_depth-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/gtxe2_chnl_rx_gearbox.sv
// rtl/gtxe2_chnl_rx_gearbox.sv - packs inner words into div-wide words and buffers them in a FIFO
// Optional statistics counters: GTXE2_RX_GEARBOX_STATS_EN
module gtxe2_chnl_rx_gearbox
  import gtxe2_rx_pkg::*;
#(
  parameter int internal_data_width = 16,
  parameter int internal_isk_width  = 2,
  parameter int div                 = 2,
  parameter int log_depth           = DEFAULT_LOG_DEPTH,
  parameter int cnt_width           = 16
) (
  input  logic                 usrclk,
  input  logic                 reset_n,
  gtxe2_chnl_rx_gearbox_if.slave bus,
  output logic                 overflow,
  input  logic                 ovf_clear,
  output logic [log_depth:0]   level
`ifdef GTXE2_RX_GEARBOX_STATS_EN
  ,
  output logic [cnt_width-1:0] stat_words,
  output logic [cnt_width-1:0] stat_drops,
  output logic [cnt_width-1:0] stat_realigns
`endif
);

  localparam int DW  = internal_data_width;
  localparam int KW  = internal_isk_width;
  localparam int OW  = iface_width(div, DW);
  localparam int OKW = iface_width(div, KW);
  localparam int FW  = total_width(OW, OKW);
  localparam int CW  = (div > 1) ? $clog2(div) : 1;

  if (!(div == 1 || div == 2 || div == 4) || log_depth < 1 || cnt_width < 1) begin : g_param_check
    $error("gtxe2_chnl_rx_gearbox: unsupported parameter set");
  end

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [OW-1:0]  bufd_q, bufd_d;
  logic [OKW-1:0] bufk_q, bufk_d;
  logic           overflow_q, overflow_d;
  logic           do_realign;
  logic           complete;
  logic           pop;
  logic           full;
  logic           empty;
  logic           drop;
  logic [FW-1:0]  fifo_head;

  assign do_realign = bus.in_val & bus.realign & (div > 1);

  always_comb begin
    cnt_d    = cnt_q;
    bufd_d   = bufd_q;
    bufk_d   = bufk_q;
    complete = 1'b0;
    if (bus.in_val) begin
      if (do_realign) begin
        bufd_d = '0;
        bufk_d = '0;
        bufd_d[lane_lsb(0, div, DW) +: DW] = bus.indata;
        bufk_d[lane_lsb(0, div, KW) +: KW] = bus.inisk;
        cnt_d  = CW'(1);
      end else begin
        for (int l = 0; l < div; l++) begin
          if (cnt_q == CW'(l)) begin
            bufd_d[lane_lsb(l, div, DW) +: DW] = bus.indata;
            bufk_d[lane_lsb(l, div, KW) +: KW] = bus.inisk;
          end
        end
        if (cnt_q == CW'(div - 1)) begin
          complete = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  assign pop  = bus.out_val & bus.out_ready;
  assign drop = complete & full & ~pop;

  // Set wins over clear so a drop in the clearing cycle is never lost.
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clear) overflow_d = 1'b0;
    if (drop)      overflow_d = 1'b1;
  end

  always_ff @(posedge usrclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      bufd_q     <= '0;
      bufk_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bufd_q     <= bufd_d;
      bufk_q     <= bufk_d;
      overflow_q <= overflow_d;
    end
  end

  // The completed word already includes the live input lane via bufd_d/bufk_d.
  gtxe2_chnl_rx_gearbox_fifo #(
    .width     (FW),
    .log_depth (log_depth)
  ) u_fifo (
    .clk       (usrclk),
    .rst_n     (reset_n),
    .push      (complete),
    .push_data ({bufk_d, bufd_d}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign bus.outdata = fifo_head[OW-1:0];
  assign bus.outisk  = fifo_head[FW-1:OW];
  assign bus.out_val = ~empty;
  assign overflow    = overflow_q;

`ifdef GTXE2_RX_GEARBOX_STATS_EN
  logic [cnt_width-1:0] words_q, words_d;
  logic [cnt_width-1:0] drops_q, drops_d;
  logic [cnt_width-1:0] realigns_q, realigns_d;

  always_comb begin
    words_d    = words_q;
    drops_d    = drops_q;
    realigns_d = realigns_q;
    if (complete & ~drop & ~&words_q)              words_d    = words_q + cnt_width'(1);
    if (drop & ~&drops_q)                          drops_d    = drops_q + cnt_width'(1);
    if (bus.in_val & bus.realign & ~&realigns_q)   realigns_d = realigns_q + cnt_width'(1);
  end

  always_ff @(posedge usrclk or negedge reset_n) begin
    if (!reset_n) begin
      words_q    <= '0;
      drops_q    <= '0;
      realigns_q <= '0;
    end else begin
      words_q    <= words_d;
      drops_q    <= drops_d;
      realigns_q <= realigns_d;
    end
  end

  assign stat_words    = words_q;
  assign stat_drops    = drops_q;
  assign stat_realigns = realigns_q;
`endif

endmodule

// File: tb/tb_gtxe2_chnl_rx_gearbox.sv
// tb/tb_gtxe2_chnl_rx_gearbox.sv - directed and random checks of the RX gearbox at div=2 and div=4
module tb_gtxe2_chnl_rx_gearbox;

  logic usrclk = 1'b0;
  always #5 usrclk = ~usrclk;

  logic       reset_n;
  logic       ovf2, clr2, ovf4, clr4;
  logic [3:0] lvl2, lvl4;

  gtxe2_chnl_rx_gearbox_if #(.internal_data_width(16), .internal_isk_width(2), .div(2)) if2 ();
  gtxe2_chnl_rx_gearbox_if #(.internal_data_width(16), .internal_isk_width(2), .div(4)) if4 ();

  gtxe2_chnl_rx_gearbox #(.div(2), .log_depth(3)) u_d2 (
    .usrclk (usrclk), .reset_n (reset_n), .bus (if2),
    .overflow (ovf2), .ovf_clear (clr2), .level (lvl2)
  );

  gtxe2_chnl_rx_gearbox #(.div(4), .log_depth(3)) u_d4 (
    .usrclk (usrclk), .reset_n (reset_n), .bus (if4),
    .overflow (ovf4), .ovf_clear (clr4), .level (lvl4)
  );

  int checks   = 0;
  int failures = 0;
  int mdiv     = 2;

  // Reference: received inner words of the current partial group, and the queue of packed words.
  logic [17:0] part [$];
  logic [71:0] expq [$];
  logic        exp_ovf = 1'b0;

  logic [63:0] o_data;
  logic [7:0]  o_isk;
  logic        o_val;
  logic [3:0]  o_lvl;
  logic        o_ovf;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    if (mdiv == 2) begin
      o_data = {32'h0, if2.outdata};
      o_isk  = {4'h0, if2.outisk};
      o_val  = if2.out_val;
      o_lvl  = lvl2;
      o_ovf  = ovf2;
    end else begin
      o_data = if4.outdata;
      o_isk  = if4.outisk;
      o_val  = if4.out_val;
      o_lvl  = lvl4;
      o_ovf  = ovf4;
    end
  endtask

  task automatic check_outputs(input string tag);
    observe();
    chk({tag, "_val"}, 72'(o_val), 72'(expq.size() != 0));
    chk({tag, "_level"}, 72'(o_lvl), 72'(expq.size()));
    chk({tag, "_ovf"}, 72'(o_ovf), 72'(exp_ovf));
    if (expq.size() != 0) begin
      chk({tag, "_data"}, 72'(o_data), 72'(expq[0][63:0]));
      chk({tag, "_isk"}, 72'(o_isk), 72'(expq[0][71:64]));
    end
  endtask

  task automatic idle_all();
    if2.indata = '0; if2.inisk = '0; if2.in_val = 1'b0; if2.realign = 1'b0; if2.out_ready = 1'b0;
    if4.indata = '0; if4.inisk = '0; if4.in_val = 1'b0; if4.realign = 1'b0; if4.out_ready = 1'b0;
    clr2 = 1'b0;
    clr4 = 1'b0;
  endtask

  task automatic step(input logic iv, input logic [15:0] d, input logic [1:0] k,
                      input logic ra, input logic rdy, input logic clr);
    int          sz;
    logic        pop;
    logic        drop;
    logic [71:0] w;
    idle_all();
    if (mdiv == 2) begin
      if2.in_val = iv; if2.indata = d; if2.inisk = k; if2.realign = ra; if2.out_ready = rdy; clr2 = clr;
    end else begin
      if4.in_val = iv; if4.indata = d; if4.inisk = k; if4.realign = ra; if4.out_ready = rdy; clr4 = clr;
    end
    sz   = expq.size();
    pop  = (sz != 0) && rdy;
    drop = 1'b0;
    if (pop) void'(expq.pop_front());
    if (iv) begin
      if (ra && mdiv > 1) begin
        part.delete();
        part.push_back({k, d});
      end else begin
        part.push_back({k, d});
        if (part.size() == mdiv) begin
          w = '0;
          for (int i = 0; i < mdiv; i++) begin
            w[i*16 +: 16]   = part[i][15:0];
            w[64+i*2 +: 2]  = part[i][17:16];
          end
          part.delete();
          if (sz < 8 || pop) expq.push_back(w);
          else drop = 1'b1;
        end
      end
    end
    if (drop) exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    @(posedge usrclk);
    #1;
    check_outputs("step");
  endtask

  task automatic rand_phase(input int n, input int rdy_pct);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(0, 3) != 0, 16'($urandom), 2'($urandom),
           $urandom_range(0, 15) == 0, $urandom_range(0, 99) < rdy_pct,
           $urandom_range(0, 31) == 0);
    end
  endtask

  initial begin
    idle_all();
    reset_n = 1'b0;
    #3;
    check_outputs("reset");
    observe();
    chk("reset_data", 72'(o_data), 72'h0);
    chk("reset_isk", 72'(o_isk), 72'h0);
    @(negedge usrclk);
    reset_n = 1'b1;

    // Basic two-lane packing
    step(1'b1, 16'h1111, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 2'b00, 1'b0, 1'b0, 1'b0);
    observe();
    chk("pack_data", 72'(o_data), 72'h22221111);
    chk("pack_isk", 72'(o_isk), 72'h01);
    chk("pack_val", 72'(o_val), 72'h1);
    step(1'b0, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0);

    // Realign discards the partial word
    step(1'b1, 16'hAAAA, 2'b00, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'hBC50, 2'b01, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'h1234, 2'b00, 1'b0, 1'b1, 1'b0);
    observe();
    chk("realign_data", 72'(o_data), 72'h1234BC50);
    chk("realign_isk", 72'(o_isk), 72'h01);
    step(1'b0, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0);

    // Fill, push with pop at full, overflow and clear priority
    for (int i = 0; i < 16; i++) step(1'b1, 16'($urandom), 2'($urandom), 1'b0, 1'b0, 1'b0);
    observe();
    chk("full_level", 72'(o_lvl), 72'd8);
    chk("full_ovf", 72'(o_ovf), 72'd0);
    step(1'b1, 16'($urandom), 2'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'($urandom), 2'($urandom), 1'b0, 1'b1, 1'b0);
    observe();
    chk("pushpop_level", 72'(o_lvl), 72'd8);
    chk("pushpop_ovf", 72'(o_ovf), 72'd0);
    step(1'b1, 16'($urandom), 2'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'($urandom), 2'($urandom), 1'b0, 1'b0, 1'b0);
    observe();
    chk("drop_level", 72'(o_lvl), 72'd8);
    chk("drop_ovf", 72'(o_ovf), 72'd1);
    step(1'b1, 16'($urandom), 2'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'($urandom), 2'($urandom), 1'b0, 1'b0, 1'b1);
    observe();
    chk("setwins_ovf", 72'(o_ovf), 72'd1);
    step(1'b0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    observe();
    chk("clear_ovf", 72'(o_ovf), 72'd0);
    for (int i = 0; i < 9; i++) step(1'b0, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0);

    rand_phase(150, 25);
    rand_phase(150, 80);

    // Reset mid-operation with two buffered entries and a partial word
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 2'($urandom), 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    part.delete();
    expq.delete();
    exp_ovf = 1'b0;
    #1;
    check_outputs("midreset");
    observe();
    chk("midreset_data", 72'(o_data), 72'h0);
    @(negedge usrclk);
    reset_n = 1'b1;
    step(1'b1, 16'h5555, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h6666, 2'b01, 1'b0, 1'b0, 1'b0);
    observe();
    chk("postreset_data", 72'(o_data), 72'h66665555);
    chk("postreset_isk", 72'(o_isk), 72'h06);
    step(1'b0, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0);

    // Four-lane packing with in_val gaps
    mdiv = 4;
    step(1'b1, 16'h0001, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'hFFFF, 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'hFFFF, 2'b11, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h0002, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0003, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'hFFFF, 2'b11, 1'b0, 1'b0, 1'b0);
    observe();
    chk("gap_notyet", 72'(o_val), 72'd0);
    step(1'b1, 16'h0004, 2'b00, 1'b0, 1'b0, 1'b0);
    observe();
    chk("gap_data", 72'(o_data), 72'h0004_0003_0002_0001);
    chk("gap_level", 72'(o_lvl), 72'd1);
    step(1'b0, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0);

    rand_phase(200, 20);
    rand_phase(200, 85);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
